frame_update_scheduler: RTL and testbench
=========================================

Name: frame_update_scheduler

Overview:
- Sequences the per-frame physics/logic updates of the game agents: player, NPC, ball, scoring/collision.
- Once per video frame, or every FRAME_DIV frames, it issues a one-cycle start pulse to each agent in fixed index order and waits for that agent's done before starting the next.
- Sits between the VGA timing generator (VSYNC) and the agent modules. Replaces free-running agent counters with a deterministic, frame-locked update order.
- Reports frame count, overruns and watchdog timeouts.

Parameters:
- N_AGENT, 3, number of sequenced agents; index 0 runs first.
- TIMEOUT_CYC, 4096, maximum cycles spent waiting for one agent's done.
- FRAME_DIV, 1, launch one update sequence every FRAME_DIV frame ticks (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- vsync  in  1  VGA VSYNC, active-low, treated as asynchronous.
- run  in  1  1 = updates enabled (game in play or wait state).
- done_i  in  N_AGENT  per-agent completion pulse.
- start_o  out  N_AGENT  one-hot, one-cycle start pulse.
- busy  out  1  high while a sequence is in progress.
- frame_cnt  out  16  completed sequences, wraps 0xFFFF→0.
- overrun  out  8  launch ticks dropped while busy, saturates at 255.
- timeout_flag  out  1  sticky; set when any agent times out.

Behaviour:
- Reset values:
  - start_o=0, busy=0, frame_cnt=0, overrun=0, timeout_flag=0.
  - State IDLE, agent index idx=0, divider=0, wait counter=0.
  - Both vsync synchroniser flops and the previous-value flop reset to 1.
- Frame tick:
  - Two-flop synchroniser, then falling-edge detect: tick = s2_prev & ~s2.
  - Counting the edge that first samples vsync low as edge 1, tick is high in the cycle after edge 2.
- Divider:
  - Counts ticks only while run=1.
  - The tick on which the divider equals FRAME_DIV-1 is a launch tick; the divider returns to 0 on that tick.
  - While run=0 the divider holds at 0.
- States:
  - IDLE: on a launch tick → ISSUE with idx=0.
  - ISSUE: start_o[idx]=1 for exactly this one cycle (combinational decode of state and idx). Wait counter cleared; → WAIT.
  - WAIT: counts cycles.
    - done_i[idx]=1 → NEXT.
    - Wait counter reaches TIMEOUT_CYC-1 → set timeout_flag, → NEXT.
    - done and timeout in the same cycle: done wins and timeout_flag is not set.
  - NEXT: if idx==N_AGENT-1, then frame_cnt+1 and → IDLE; else idx+1 and → ISSUE.
- Latency and throughput:
  - start_o[0] is high in the cycle after edge 3 (FRAME_DIV=1).
  - Each agent costs ≥3 cycles: ISSUE, ≥1 WAIT, NEXT.
- busy = (state != IDLE).
- done_i is ignored in IDLE, ISSUE and NEXT, and on bits other than idx. Agents must pulse done at least 1 cycle after start.
- Launch tick while busy: the tick is dropped, overrun+1 saturating at 255, and the current sequence is unaffected.
- run falling mid-sequence: in the next cycle state → IDLE and idx → 0. No further start pulses; frame_cnt not incremented; overrun and timeout_flag hold.
- Reset mid-sequence: returns immediately to reset values on the clock edge; any start pulse in progress is cut.
- timeout_flag clears only on reset.

Optional Feature:
- Macro: AGENT_MASK_EN.
- Defined:
  - Extra input agent_en [N_AGENT-1:0], sampled in NEXT and at launch.
  - Agents with agent_en=0 are skipped: no start pulse, no WAIT, and the index advances in the same NEXT evaluation to the next enabled agent.
  - All agents disabled at launch: stay IDLE, frame_cnt still increments.
- Undefined: every agent is always sequenced. No agent_en port exists.

Decomposition:
- Shared package pika_pkg:
  - Scheduler state encoding (IDLE/ISSUE/WAIT/NEXT, 2 bits).
  - Agent index constants: AGENT_PLAYER=0, AGENT_NPC=1, AGENT_BALL=2.
  - Default TIMEOUT_CYC.
- One sub-module, vsync_tick_gen: synchroniser, edge detect and FRAME_DIV divider, outputting launch_tick. The FSM, counters and flags stay in the parent.

Test Plan:
- Reset, run=1, one vsync fall, agents answer done 2 cycles after start → start_o pulses 001, 010, 100 in order, each exactly 1 cycle; busy high throughout; frame_cnt=1.
- FRAME_DIV=3, 6 vsync falls → exactly 2 sequences; frame_cnt=2.
- Agent 1 never asserts done → WAIT lasts TIMEOUT_CYC cycles; timeout_flag=1; agent 2 still starts; frame_cnt=1.
- Agent 0 holds done off across 3 further launch ticks → overrun=3. Continue to 300 ticks → overrun stays at 255.
- run dropped while waiting on agent 1 → no agent 2 pulse; busy=0 the next cycle; frame_cnt unchanged. done_i[1] arriving afterwards has no effect.
- With AGENT_MASK_EN, agent_en=101 → pulses only on bits 0 and 2; frame_cnt=1.

Source files
------------

// File: rtl/pika_pkg.sv
// Shared scheduler types and constants for the frame update scheduler.
// Optional agent masking is enabled by defining AGENT_MASK_EN.
package pika_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_NEXT  = 2'd3
  } sched_state_t;

  localparam int AGENT_PLAYER = 0;
  localparam int AGENT_NPC    = 1;
  localparam int AGENT_BALL   = 2;

  localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/vsync_tick_gen.sv
// VSYNC synchroniser, falling-edge detect and frame divider.
// Produces a one-cycle launch_tick every FRAME_DIV frames while run=1.
module vsync_tick_gen #(
  parameter int FRAME_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync,
  input  logic run,
  output logic launch_tick
);

  logic       s1;
  logic       s2;
  logic       s2_prev;
  logic       tick;
  logic [7:0] div;
  logic       div_hit;

  assign tick    = s2_prev & ~s2;
  assign div_hit = (div == 8'(FRAME_DIV - 1));

  assign launch_tick = tick & run & div_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s2_prev <= 1'b1;
      div     <= '0;
    end else begin
      s1      <= vsync;
      s2      <= s1;
      s2_prev <= s2;
      if (!run) begin
        div <= '0;
      end else if (tick) begin
        div <= div_hit ? '0 : div + 8'd1;
      end
    end
  end

endmodule

// File: rtl/frame_update_scheduler.sv
// Frame-locked sequencer issuing start pulses to agents in index order.
// Define AGENT_MASK_EN to add agent_en and skip disabled agents.
module frame_update_scheduler
  import pika_pkg::*;
#(
  parameter int N_AGENT     = 3,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FRAME_DIV   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               run,
`ifdef AGENT_MASK_EN
  input  logic [N_AGENT-1:0] agent_en,
`endif
  input  logic [N_AGENT-1:0] done_i,
  output logic [N_AGENT-1:0] start_o,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic [7:0]         overrun,
  output logic               timeout_flag
);

  localparam int IW = (N_AGENT > 1) ? $clog2(N_AGENT) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_t  state;
  logic [IW-1:0] idx;
  logic [TW-1:0] wait_cnt;
  logic          launch_tick;
  logic          last_agent;

  vsync_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .run        (run),
    .launch_tick(launch_tick)
  );

  always_comb begin
    start_o = '0;
    if (state == S_ISSUE) start_o[idx] = 1'b1;
  end

  assign busy       = (state != S_IDLE);
  assign last_agent = (idx == IW'(N_AGENT - 1));

`ifdef AGENT_MASK_EN
  // {found, index} of the lowest enabled agent at or above from
  function automatic logic [IW:0] pick(
    input logic [N_AGENT-1:0] en,
    input int                 from
  );
    logic          found;
    logic [IW-1:0] r;
    found = 1'b0;
    r     = '0;
    for (int i = N_AGENT - 1; i >= 0; i--) begin
      if (i >= from && en[i]) begin
        found = 1'b1;
        r     = IW'(i);
      end
    end
    return {found, r};
  endfunction

  logic [IW:0] first_en;
  logic [IW:0] next_en;

  assign first_en = pick(agent_en, 0);
  assign next_en  = pick(agent_en, int'(idx) + 1);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      wait_cnt     <= '0;
      frame_cnt    <= '0;
      overrun      <= '0;
      timeout_flag <= 1'b0;
    end else if (!run) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      if (launch_tick && busy && overrun != 8'hFF)
        overrun <= overrun + 8'd1;
      unique case (state)
        S_IDLE: begin
          if (launch_tick) begin
`ifdef AGENT_MASK_EN
            if (first_en[IW]) begin
              idx   <= first_en[IW-1:0];
              state <= S_ISSUE;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
`else
            idx   <= '0;
            state <= S_ISSUE;
`endif
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (done_i[idx]) begin
            state <= S_NEXT;
          end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout_flag <= 1'b1;
            state        <= S_NEXT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_NEXT: begin
`ifdef AGENT_MASK_EN
          if (next_en[IW]) begin
            idx   <= next_en[IW-1:0];
            state <= S_ISSUE;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
            idx       <= '0;
            state     <= S_IDLE;
          end
`else
          if (last_agent) begin
            frame_cnt <= frame_cnt + 16'd1;
            idx       <= '0;
            state     <= S_IDLE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_ISSUE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AGENT_MASK_EN
  logic unused_last;
  assign unused_last = last_agent;
`endif

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed scoreboard bench for frame_update_scheduler.
// Two instances: FRAME_DIV=1 (a) and FRAME_DIV=3 (b), TIMEOUT_CYC=64.
module tb_frame_update_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  logic vsync_a, vsync_b;
  logic run_a, run_b;
  logic [2:0] done_a, done_b;
  logic [2:0] start_a, start_b;
  logic busy_a, busy_b;
  logic [15:0] fcnt_a, fcnt_b;
  logic [7:0] ovr_a, ovr_b;
  logic to_a, to_b;
  logic [2:0] agent_en_a = 3'b111;

  logic [2:0] resp_a = 3'b111;
  logic [2:0] force_a = 3'b000;
  logic [2:0] d1a = '0, d2a = '0;
  logic [2:0] d1b = '0, d2b = '0;

  int tests = 0;
  int fails = 0;
  bit sb_on_a = 1'b1;
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  logic [2:0] prev_a = '0, prev_b = '0;
  int cyc;

  always #5 clk = ~clk;

  frame_update_scheduler #(
    .N_AGENT(3), .TIMEOUT_CYC(64), .FRAME_DIV(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .vsync(vsync_a), .run(run_a),
`ifdef AGENT_MASK_EN
    .agent_en(agent_en_a),
`endif
    .done_i(done_a), .start_o(start_a), .busy(busy_a),
    .frame_cnt(fcnt_a), .overrun(ovr_a), .timeout_flag(to_a)
  );

  frame_update_scheduler #(
    .N_AGENT(3), .TIMEOUT_CYC(64), .FRAME_DIV(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .vsync(vsync_b), .run(run_b),
`ifdef AGENT_MASK_EN
    .agent_en(3'b111),
`endif
    .done_i(done_b), .start_o(start_b), .busy(busy_b),
    .frame_cnt(fcnt_b), .overrun(ovr_b), .timeout_flag(to_b)
  );

  // agents answer done two cycles after their start pulse
  always @(posedge clk) begin
    d1a <= start_a & resp_a;
    d2a <= d1a;
    d1b <= start_b;
    d2b <= d1b;
  end
  assign done_a = d2a | force_a;
  assign done_b = d2b;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_on_a && start_a != 3'b000) begin
      if (qa.size() == 0) chk("sb_a_extra", 32'(start_a), 32'd0);
      else chk("sb_a", 32'(start_a), 32'(qa.pop_front()));
      chk("width_a", 32'(prev_a), 32'd0);
    end
    if (start_b != 3'b000) begin
      if (qb.size() == 0) chk("sb_b_extra", 32'(start_b), 32'd0);
      else chk("sb_b", 32'(start_b), 32'(qb.pop_front()));
      chk("width_b", 32'(prev_b), 32'd0);
    end
    prev_a <= start_a;
    prev_b <= start_b;
  end

  task automatic push_a(input logic [2:0] a, b, c);
    qa.push_back(a); qa.push_back(b); qa.push_back(c);
  endtask

  task automatic fall(input bit sel_b);
    @(negedge clk);
    if (sel_b) vsync_b = 1'b1; else vsync_a = 1'b1;
    repeat (3) @(negedge clk);
    if (sel_b) vsync_b = 1'b0; else vsync_a = 1'b0;
    repeat (4) @(negedge clk);
    if (sel_b) vsync_b = 1'b1; else vsync_a = 1'b1;
  endtask

  // vsync fall on a; returns in the cycle start_o[0] is expected
  task automatic launch_a();
    repeat (4) @(negedge clk);
    vsync_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("launch_start", 32'(start_a), 32'd1);
    chk("launch_busy", 32'(busy_a), 32'd1);
    vsync_a = 1'b1;
  endtask

  task automatic wait_idle_a(input int budget, output int n);
    n = 0;
    while (busy_a && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) chk("idle_budget_a", 32'(busy_a), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    vsync_a = 1'b1; vsync_b = 1'b1;
    run_a = 1'b0; run_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 32'(start_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_fcnt", 32'(fcnt_a), 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    chk("rst_to", 32'(to_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_a = 1'b1;

    // basic sequence
    push_a(3'b001, 3'b010, 3'b100);
    launch_a();
    wait_idle_a(100, cyc);
    chk("t1_busy_cycles", 32'(cyc), 32'd12);
    chk("t1_fcnt", 32'(fcnt_a), 32'd1);
    chk("t1_ovr", 32'(ovr_a), 32'd0);
    chk("t1_to", 32'(to_a), 32'd0);
    chk("t1_q", 32'(qa.size()), 32'd0);

    // FRAME_DIV=3: six falls, two sequences
    run_b = 1'b1;
    for (int i = 0; i < 6; i++) qb.push_back(3'b001 << (i % 3));
    for (int i = 0; i < 6; i++) begin
      fall(1'b1);
      repeat (16) @(negedge clk);
    end
    chk("t2_fcnt_b", 32'(fcnt_b), 32'd2);
    chk("t2_q_b", 32'(qb.size()), 32'd0);
    chk("t2_ovr_b", 32'(ovr_b), 32'd0);

    // agent 1 silent: timeout
    resp_a = 3'b101;
    push_a(3'b001, 3'b010, 3'b100);
    launch_a();
    wait_idle_a(200, cyc);
    chk("t3_busy_cycles", 32'(cyc), 32'd74);
    chk("t3_to", 32'(to_a), 32'd1);
    chk("t3_fcnt", 32'(fcnt_a), 32'd2);
    chk("t3_q", 32'(qa.size()), 32'd0);

    // agent 0 silent: overrun counting and saturation
    resp_a = 3'b110;
    qa.push_back(3'b001);
    launch_a();
    for (int i = 0; i < 3; i++) fall(1'b0);
    chk("t4_ovr3", 32'(ovr_a), 32'd3);
    chk("t4_busy", 32'(busy_a), 32'd1);
    chk("t4_q", 32'(qa.size()), 32'd0);
    sb_on_a = 1'b0;
    for (int i = 0; i < 297; i++) fall(1'b0);
    wait_idle_a(500, cyc);
    chk("t4_ovr_sat", 32'(ovr_a), 32'd255);
    chk("t4_to", 32'(to_a), 32'd1);
    repeat (2) @(negedge clk);
    qa.delete();
    sb_on_a = 1'b1;

    // reset in the middle of a sequence
    resp_a = 3'b111;
    qa.push_back(3'b001);
    launch_a();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_start", 32'(start_a), 32'd0);
    chk("t5_busy", 32'(busy_a), 32'd0);
    chk("t5_fcnt", 32'(fcnt_a), 32'd0);
    chk("t5_ovr", 32'(ovr_a), 32'd0);
    chk("t5_to", 32'(to_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // run dropped while waiting on agent 1
    resp_a = 3'b101;
    qa.push_back(3'b001);
    qa.push_back(3'b010);
    launch_a();
    cyc = 0;
    while (!start_a[1] && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t6_reach_agent1", 32'(start_a), 32'd2);
    repeat (3) @(negedge clk);
    run_a = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_busy", 32'(busy_a), 32'd0);
    chk("t6_fcnt", 32'(fcnt_a), 32'd0);
    repeat (20) @(negedge clk);
    run_a = 1'b1;
    force_a = 3'b010;
    @(negedge clk);
    force_a = 3'b000;
    repeat (10) @(negedge clk);
    chk("t6_busy_late", 32'(busy_a), 32'd0);
    chk("t6_fcnt_late", 32'(fcnt_a), 32'd0);
    chk("t6_to", 32'(to_a), 32'd0);
    chk("t6_q", 32'(qa.size()), 32'd0);

    // recovery
    resp_a = 3'b111;
    push_a(3'b001, 3'b010, 3'b100);
    launch_a();
    wait_idle_a(100, cyc);
    chk("t7_busy_cycles", 32'(cyc), 32'd12);
    chk("t7_fcnt", 32'(fcnt_a), 32'd1);

`ifdef AGENT_MASK_EN
    agent_en_a = 3'b101;
    qa.push_back(3'b001);
    qa.push_back(3'b100);
    launch_a();
    wait_idle_a(100, cyc);
    chk("t8_busy_cycles", 32'(cyc), 32'd8);
    chk("t8_fcnt", 32'(fcnt_a), 32'd2);
    chk("t8_q", 32'(qa.size()), 32'd0);
    agent_en_a = 3'b111;
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
